jump_sequencer: RTL and testbench

Game-flow controller for the doodle datapath. Runs the Init / Up / Down / Done state machine whose one-hot flags drive the doodle position register (`q_I`, `q_Up`, `q_Down`, `q_Done`). It tracks jump height, detects landings and falls off the bottom edge, and generates the platform scroll offset and the score. It sits between the debounced buttons / platform-hit logic and the VGA object controller, clocked by the same slow game clock.

---
 rtl/jump_sequencer_if.sv | 30 +++
 rtl/jump_sequencer.sv | 114 +++++++++++
 tb/tb_jump_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jump_sequencer_if.sv
// Doodle game-flow bus: step/button/platform inputs in, one-hot flags, scroll and score out.
// The hiscore signal exists only when JUMP_SEQ_HISCORE_EN is defined.
interface jump_sequencer_if;
  localparam int unsigned YPOS_W  = 10;
  localparam int unsigned SCORE_W = 8;

  logic                tick;
  logic                start;
  logic                land;
  logic [YPOS_W-1:0]   ypos;
  logic                q_I;
  logic                q_Up;
  logic                q_Down;
  logic                q_Done;
  logic [YPOS_W-1:0]   scroll;
  logic [SCORE_W-1:0]  score;
`ifdef JUMP_SEQ_HISCORE_EN
  logic [SCORE_W-1:0]  hiscore;

  modport master (output tick, start, land, ypos,
                  input  q_I, q_Up, q_Down, q_Done, scroll, score, hiscore);
  modport slave  (input  tick, start, land, ypos,
                  output q_I, q_Up, q_Down, q_Done, scroll, score, hiscore);
`else
  modport master (output tick, start, land, ypos,
                  input  q_I, q_Up, q_Down, q_Done, scroll, score);
  modport slave  (input  tick, start, land, ypos,
                  output q_I, q_Up, q_Down, q_Done, scroll, score);
`endif
endinterface

// File: rtl/jump_sequencer.sv
// Init/Up/Down/Done game-flow FSM: jump height, landings, falls, platform scroll and score.
// Optional best-score register enabled by defining JUMP_SEQ_HISCORE_EN.
module jump_sequencer #(
  parameter int unsigned JUMP_HEIGHT = 120,
  parameter int unsigned STEP        = 2,
  parameter int unsigned FLOOR_Y     = 505,
  parameter int unsigned SCROLL_Y    = 200
) (
  input  logic              clk,
  input  logic              rst,
  jump_sequencer_if.slave   bus
);
  localparam int unsigned JUMP_W  = 8;
  localparam int unsigned POS_W   = 10;
  localparam int unsigned SCORE_W = 8;

  typedef enum logic [1:0] {
    INI  = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [JUMP_W-1:0]    jump_cnt_q, jump_cnt_d;
  logic [POS_W-1:0]     scroll_q, scroll_d;
  logic [SCORE_W-1:0]   score_q, score_d;
`ifdef JUMP_SEQ_HISCORE_EN
  logic [SCORE_W-1:0]   hiscore_q, hiscore_d;
`endif

  // Next-state and counter updates; only start transitions ignore tick.
  always_comb begin
    state_d    = state_q;
    jump_cnt_d = jump_cnt_q;
    scroll_d   = scroll_q;
    score_d    = score_q;
`ifdef JUMP_SEQ_HISCORE_EN
    hiscore_d  = hiscore_q;
`endif
    case (state_q)
      INI: begin
        if (bus.start) begin
          state_d    = UP;
          jump_cnt_d = '0;
          scroll_d   = '0;
          score_d    = '0;
        end
      end
      UP: begin
        if (bus.tick) begin
          if (bus.ypos <= POS_W'(SCROLL_Y)) scroll_d = scroll_q + POS_W'(STEP);
          // Last climbing step compares the pre-increment count so it never exceeds the height.
          if (jump_cnt_q == JUMP_W'(JUMP_HEIGHT - STEP)) begin
            state_d    = DOWN;
            jump_cnt_d = '0;
          end else begin
            jump_cnt_d = jump_cnt_q + JUMP_W'(STEP);
          end
        end
      end
      DOWN: begin
        if (bus.tick) begin
          if (bus.land) begin
            state_d    = UP;
            jump_cnt_d = '0;
            if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
          end else if (bus.ypos >= POS_W'(FLOOR_Y)) begin
            state_d = DONE;
`ifdef JUMP_SEQ_HISCORE_EN
            if (score_q > hiscore_q) hiscore_d = score_q;
`endif
          end
        end
      end
      DONE: begin
        if (bus.start) state_d = INI;
      end
      default: state_d = INI;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INI;
      jump_cnt_q <= '0;
      scroll_q   <= '0;
      score_q    <= '0;
`ifdef JUMP_SEQ_HISCORE_EN
      hiscore_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      jump_cnt_q <= jump_cnt_d;
      scroll_q   <= scroll_d;
      score_q    <= score_d;
`ifdef JUMP_SEQ_HISCORE_EN
      hiscore_q  <= hiscore_d;
`endif
    end
  end

  // Flags decode straight from the state register, no input-to-output path.
  assign bus.q_I    = (state_q == INI);
  assign bus.q_Up   = (state_q == UP);
  assign bus.q_Down = (state_q == DOWN);
  assign bus.q_Done = (state_q == DONE);
  assign bus.scroll = scroll_q;
  assign bus.score  = score_q;
`ifdef JUMP_SEQ_HISCORE_EN
  assign bus.hiscore = hiscore_q;
`endif

endmodule

// File: tb/tb_jump_sequencer.sv
// Bench for jump_sequencer: vector table, scoreboarded reference model, and hand-written game sequences.
module tb_jump_sequencer;
  localparam int unsigned JH    = 120;
  localparam int unsigned STP   = 2;
  localparam int unsigned FLOOR = 505;
  localparam int unsigned SCR   = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jump_sequencer_if bus ();

  jump_sequencer #(
    .JUMP_HEIGHT(JH),
    .STEP       (STP),
    .FLOOR_Y    (FLOOR),
    .SCROLL_Y   (SCR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] flags;   // {done, down, up, init}
    int         scroll;
    int         score;
    int         hi;
  } exp_t;

  typedef struct {
    bit         t, s, l;
    int         y;
    logic [3:0] fl;
    int         scr;
    int         sc;
  } vec_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: 0=INI 1=UP 2=DOWN 3=DONE
  int m_state, m_jump, m_scroll, m_score, m_hi;

  function automatic void model_reset(input bit clear_hi);
    m_state = 0; m_jump = 0; m_scroll = 0; m_score = 0;
    if (clear_hi) m_hi = 0;
  endfunction

  function automatic void model_step(input bit t, input bit s, input bit l, input int y);
    case (m_state)
      0: if (s) begin m_state = 1; m_jump = 0; m_scroll = 0; m_score = 0; end
      1: if (t) begin
           if (y <= int'(SCR)) m_scroll = (m_scroll + int'(STP)) % 1024;
           m_jump += int'(STP);
           if (m_jump == int'(JH)) begin m_state = 2; m_jump = 0; end
         end
      2: if (t) begin
           if (l) begin
             m_state = 1; m_jump = 0;
             if (m_score < 255) m_score++;
           end else if (y >= int'(FLOOR)) begin
             m_state = 3;
             if (m_score > m_hi) m_hi = m_score;
           end
         end
      default: if (s) m_state = 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.q_Done, bus.q_Down, bus.q_Up, bus.q_I};
  endfunction

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(1), 32'(0));
      return;
    end
    e = sb_q.pop_front();
    check("sb_flags",  32'(flags()),     32'(e.flags));
    check("sb_scroll", 32'(bus.scroll),  32'(e.scroll));
    check("sb_score",  32'(bus.score),   32'(e.score));
`ifdef JUMP_SEQ_HISCORE_EN
    check("sb_hiscore", 32'(bus.hiscore), 32'(e.hi));
`endif
  endtask

  // One clock: drive at negedge, push model expectation, compare after the edge.
  task automatic cyc(input bit t, input bit s, input bit l, input int y);
    exp_t e;
    @(negedge clk);
    bus.tick = t; bus.start = s; bus.land = l; bus.ypos = 10'(y);
    model_step(t, s, l, y);
    e.flags  = 4'(1 << m_state);
    e.scroll = m_scroll;
    e.score  = m_score;
    e.hi     = m_hi;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic climb(input int y);
    repeat (JH / STP) cyc(1'b1, 1'b0, 1'b0, y);
    check("climb_to_down", 32'(bus.q_Down), 32'(1));
  endtask

  task automatic run_to_down(input int y);
    int n;
    n = 0;
    while (!bus.q_Down && n < 200) begin
      cyc(1'b1, 1'b0, 1'b0, y);
      n++;
    end
    check("run_to_down_timeout", 32'(bus.q_Down), 32'(1));
  endtask

`ifdef JUMP_SEQ_HISCORE_EN
  task automatic play(input int n_land, input int exp_hi);
    cyc(1'b0, 1'b1, 1'b0, 300);
    climb(300);
    repeat (n_land) begin
      cyc(1'b1, 1'b0, 1'b1, 300);
      climb(300);
    end
    cyc(1'b1, 1'b0, 1'b0, 506);
    check("game_end_done",  32'(bus.q_Done),  32'(1));
    check("game_end_score", 32'(bus.score),   32'(n_land));
    check("game_end_hi",    32'(bus.hiscore), 32'(exp_hi));
    cyc(1'b0, 1'b1, 1'b0, 300);
  endtask
`endif

  vec_t vecs[9];
  int   up_ticks;
  int   guard;

  initial begin
    vecs[0] = '{t:0, s:0, l:0, y:300, fl:4'b0001, scr:0, sc:0};
    vecs[1] = '{t:0, s:1, l:0, y:300, fl:4'b0010, scr:0, sc:0};
    vecs[2] = '{t:1, s:0, l:0, y:150, fl:4'b0010, scr:2, sc:0};
    vecs[3] = '{t:0, s:0, l:0, y:150, fl:4'b0010, scr:2, sc:0};
    vecs[4] = '{t:1, s:0, l:0, y:300, fl:4'b0010, scr:2, sc:0};
    vecs[5] = '{t:1, s:1, l:0, y:150, fl:4'b0010, scr:4, sc:0};
    vecs[6] = '{t:1, s:0, l:1, y:150, fl:4'b0010, scr:6, sc:0};
    vecs[7] = '{t:1, s:1, l:1, y:200, fl:4'b0010, scr:8, sc:0};
    vecs[8] = '{t:1, s:0, l:0, y:201, fl:4'b0010, scr:8, sc:0};

    rst = 1'b0;
    bus.tick = 1'b0; bus.start = 1'b0; bus.land = 1'b0; bus.ypos = 10'd300;
    model_reset(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags",  32'(flags()),    32'(4'b0001));
    check("reset_scroll", 32'(bus.scroll), 32'(0));
    check("reset_score",  32'(bus.score),  32'(0));
`ifdef JUMP_SEQ_HISCORE_EN
    check("reset_hiscore", 32'(bus.hiscore), 32'(0));
`endif
    @(negedge clk);
    rst = 1'b1;

    // Table vectors from INI through early UP
    foreach (vecs[i]) begin
      cyc(vecs[i].t, vecs[i].s, vecs[i].l, vecs[i].y);
      check($sformatf("vec%0d_flags", i),  32'(flags()),    32'(vecs[i].fl));
      check($sformatf("vec%0d_scroll", i), 32'(bus.scroll), 32'(vecs[i].scr));
      check($sformatf("vec%0d_score", i),  32'(bus.score),  32'(vecs[i].sc));
    end

    // Fall off the bottom edge, then the two-start restart
    run_to_down(300);
    for (int y = 480; y <= 506; y += 2) begin
      cyc(1'b1, 1'b0, 1'b0, y);
      if (y == 504) check("fall_504_still_down", 32'(bus.q_Down), 32'(1));
    end
    check("fall_506_done", 32'(bus.q_Done), 32'(1));
    cyc(1'b1, 1'b0, 1'b1, 300);
    check("done_ignores_land", 32'(bus.q_Done), 32'(1));
    cyc(1'b0, 1'b1, 1'b0, 300);
    check("done_start_ini",    32'(bus.q_I),    32'(1));
    check("ini_scroll_held",   32'(bus.scroll), 32'(8));
    cyc(1'b0, 1'b1, 1'b0, 300);
    check("restart_up",        32'(bus.q_Up),   32'(1));
    check("restart_scroll0",   32'(bus.scroll), 32'(0));

    // UP duration with a tick every 4 clocks, scrolling at ypos=150
    up_ticks = 0;
    guard = 0;
    while (!bus.q_Down && guard < 1000) begin
      if (guard % 4 == 0) begin
        if (bus.q_Up) up_ticks++;
        cyc(1'b1, 1'b0, 1'b0, 150);
      end else begin
        cyc(1'b0, 1'b0, 1'b0, 150);
      end
      guard++;
    end
    check("up_tick_count", 32'(up_ticks),   32'(60));
    check("up_then_down",  32'(bus.q_Down), 32'(1));
    check("scroll_120",    32'(bus.scroll), 32'(120));

    // Landing; tick low holds
    cyc(1'b0, 1'b0, 1'b1, 300);
    check("no_tick_hold", 32'(bus.q_Down), 32'(1));
    cyc(1'b1, 1'b0, 1'b1, 300);
    check("land_up",      32'(bus.q_Up),   32'(1));
    check("land_score1",  32'(bus.score),  32'(1));
    climb(300);
    check("no_scroll_low", 32'(bus.scroll), 32'(120));

    // Scroll wrap: eight more scrolling climbs take 120 to 1080 mod 1024
    repeat (8) begin
      cyc(1'b1, 1'b0, 1'b1, 150);
      climb(150);
    end
    check("scroll_wrap", 32'(bus.scroll), 32'(56));
    check("score_9",     32'(bus.score),  32'(9));

    // Score saturation
    repeat (251) begin
      cyc(1'b1, 1'b0, 1'b1, 300);
      climb(300);
    end
    check("score_sat", 32'(bus.score), 32'(255));

    // Land beats floor on the same tick
    cyc(1'b1, 1'b0, 1'b1, 510);
    check("land_beats_floor", 32'(bus.q_Up),  32'(1));
    check("score_sat_hold",   32'(bus.score), 32'(255));
    climb(300);
    cyc(1'b1, 1'b0, 1'b0, 506);
    check("fall2_done", 32'(bus.q_Done), 32'(1));
    cyc(1'b0, 1'b1, 1'b0, 300);
    check("ini_score_held", 32'(bus.score), 32'(255));
    cyc(1'b0, 1'b1, 1'b0, 300);
    check("start_clears_score", 32'(bus.score), 32'(0));

    // Asynchronous reset between edges mid-UP
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 150);
    check("pre_rst_scroll", 32'(bus.scroll), 32'(6));
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_qi",     32'(flags()),    32'(4'b0001));
    check("async_rst_scroll", 32'(bus.scroll), 32'(0));
    model_reset(1'b1);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 300);
    check("post_rst_start", 32'(bus.q_Up), 32'(1));
    run_to_down(300);
    cyc(1'b1, 1'b0, 1'b0, 506);
    cyc(1'b0, 1'b1, 1'b0, 300);

`ifdef JUMP_SEQ_HISCORE_EN
    play(5, 5);
    play(3, 5);
    check("hiscore_survives", 32'(bus.hiscore), 32'(5));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("hiscore_rst", 32'(bus.hiscore), 32'(0));
    model_reset(1'b1);
    @(negedge clk);
    rst = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
